// File: rtl/data_mem_bridge.sv
// data_mem_bridge: decodes datapath loads/stores to an external handshaked RAM,
// a small I/O register bank or unmapped space, stalling fetch during RAM accesses.
module data_mem_bridge #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  output logic              bus_error
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata, r_cycles, w_io_rd;
  logic [7:0]        r_sw1, r_sw2, r_led;
  logic              r_we, r_berr;
  logic              w_acc, w_ram, w_io, w_unm, w_idle, w_tmo, w_io_wr, w_set, w_clr;
  logic              w_unused;
  assign w_unused = ^ALUResult[1:0];
  assign w_acc    = MemRead | MemWrite;
  assign w_idle   = r_state == IDLE;
  assign w_ram    = w_acc && ALUResult[31:ADDR_W+2] == '0;
  assign w_io     = w_acc && ALUResult[31:4] == 28'h0001000;
  assign w_unm    = w_acc && !w_ram && !w_io;
  assign w_tmo    = !ram_ack && r_cnt == CW'(TIMEOUT - 1);
  assign w_io_wr  = w_idle && w_io && MemWrite;
  assign w_set    = (w_idle && w_unm) || (r_state == ACCESS && w_tmo);
  assign w_clr    = w_io_wr && ALUResult[3:2] == 2'd3 && WriteData[0];
  assign w_io_rd  = ALUResult[3:2] == 2'd0 ? {24'b0, r_led} :
                    ALUResult[3:2] == 2'd1 ? {24'b0, r_sw2} :
                    ALUResult[3:2] == 2'd2 ? r_cycles : {31'b0, r_berr};
  assign ram_req   = r_state == ACCESS;
  assign ram_we    = r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign led       = r_led;
  assign bus_error = r_berr;
  always_comb begin
    w_next   = IDLE;
    if (w_idle) w_next = w_ram ? ACCESS : IDLE;
    else if (r_state == ACCESS) w_next = (ram_ack || w_tmo) ? DONE : ACCESS;
    Stall    = (w_idle && w_ram) || r_state == ACCESS;
    ReadData = r_state == DONE ? r_rdata : (w_idle && w_io && !MemWrite) ? w_io_rd : 32'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_rdata  <= '0;
      r_led    <= '0;
      r_berr   <= 1'b0;
      r_cycles <= '0;
      r_sw1    <= '0;
      r_sw2    <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      r_sw1    <= sw;
      r_sw2    <= r_sw1;
      r_berr   <= w_set | (r_berr & ~w_clr);
      if (w_io_wr && ALUResult[3:2] == 2'd0) r_led <= WriteData[7:0];
      if (w_idle && w_ram) begin
        r_addr  <= ALUResult[ADDR_W+1:2];
        r_wdata <= WriteData;
        r_we    <= MemWrite;
        r_cnt   <= '0;
      end
      if (r_state == ACCESS) begin
        r_cnt <= r_cnt + CW'(1);
        // writes keep the previous load data; an abort always reports the poison word
        if (ram_ack && !r_we) r_rdata <= ram_rdata;
        else if (w_tmo)       r_rdata <= 32'hDEADBEEF;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: randomized bench with a memory-array RAM responder and a register-level model.
module tb_data_mem_bridge;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 16;
  logic              clk = 1'b0, rst = 1'b0;
  logic              MemRead = 1'b0, MemWrite = 1'b0, ram_ack = 1'b0;
  logic [31:0]       ALUResult = '0, WriteData = '0, ram_rdata = '0;
  logic [7:0]        sw = '0;
  logic [31:0]       ReadData, ram_wdata;
  logic              Stall, ram_req, ram_we, bus_error;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        led;
  int                n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [7:0]        m_led = '0;
  logic              m_berr = 1'b0;
  logic [31:0]       m_rq = '0;

  data_mem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .sw(sw), .led(led), .bus_error(bus_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] io_addr(input logic [1:0] r);
    return 32'h0001_0000 | {28'b0, r, 2'b00};
  endfunction

  task automatic io_write(input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    MemWrite = 1'b1; MemRead = 1'($urandom_range(0, 1)); ALUResult = io_addr(r); WriteData = d;
    #1;
    chk("io_wr_stall", 32'(Stall), 0);
    chk("io_wr_req", 32'(ram_req), 0);
    if (r == 2'd0) m_led = d[7:0];
    if (r == 2'd3 && d[0]) m_berr = 1'b0;
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    chk("led", 32'(led), 32'(m_led));
    chk("bus_error", 32'(bus_error), 32'(m_berr));
  endtask

  task automatic io_read(input logic [1:0] r, output logic [31:0] v, output int t);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; ALUResult = io_addr(r);
    #1;
    v = ReadData; t = cyc;
    chk("io_rd_stall", 32'(Stall), 0);
    if (r != 2'd2)
      chk("io_rd", v, r == 2'd0 ? {24'b0, m_led} : r == 2'd1 ? {24'b0, sw} : {31'b0, m_berr});
    @(negedge clk);
    MemRead = 1'b0;
  endtask

  task automatic unmapped(input logic [31:0] a, input bit we);
    @(negedge clk);
    MemWrite = we; MemRead = !we; ALUResult = a; WriteData = $urandom;
    #1;
    chk("unm_stall", 32'(Stall), 0);
    chk("unm_req", 32'(ram_req), 0);
    chk("unm_rd", ReadData, 0);
    m_berr = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    chk("unm_berr", 32'(bus_error), 1);
    chk("unm_led", 32'(led), 32'(m_led));
  endtask

  task automatic ram_access(input bit we, input logic [31:0] a, input logic [31:0] d, input int waits);
    int stalls, acc;
    bit done, acked;
    logic [ADDR_W-1:0] idx;
    stalls = 0; acc = 0; done = 0; acked = 0; idx = a[ADDR_W+1:2];
    @(negedge clk);
    MemWrite = we; MemRead = we ? 1'($urandom_range(0, 1)) : 1'b1; ALUResult = a; WriteData = d;
    for (int c = 0; c < TIMEOUT + 8 && !done; c++) begin
      #1;
      if (Stall) stalls++;
      if (ram_req) begin
        acc++;
        chk("ram_addr", 32'(ram_addr), 32'(idx));
        chk("ram_we", 32'(ram_we), 32'(we));
        if (we) chk("ram_wdata", ram_wdata, d);
        chk("acc_rd", ReadData, 0);
        ram_ack = (acc == waits + 1);
        ram_rdata = ram_ack ? mem[idx] : $urandom;
        if (ram_ack) acked = 1;
      end else begin
        ram_ack = 1'b0;
        if (acc == 0) chk("stall_rd", ReadData, 0);
        else begin
          done = 1;
          if (acked) begin
            if (we) mem[idx] = d;
            else m_rq = mem[idx];
          end else begin
            m_rq = 32'hDEADBEEF;
            m_berr = 1'b1;
          end
          chk("done_stall", 32'(Stall), 0);
          chk("done_rd", ReadData, m_rq);
          chk("acc_cycles", acc, acked ? waits + 1 : TIMEOUT);
          chk("stall_cycles", stalls, acked ? waits + 2 : TIMEOUT + 1);
        end
      end
      @(negedge clk);
    end
    ram_ack = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0;
    if (!done) chk("ram_done", 0, 1);
    #1;
    chk("post_req", 32'(ram_req), 0);
    chk("post_stall", 32'(Stall), 0);
    chk("post_berr", 32'(bus_error), 32'(m_berr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v1, v2, a;
    int t1, t2, op, waits;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    #1;
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_req", 32'(ram_req), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_berr", 32'(bus_error), 0);
    chk("rst_rd", ReadData, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    io_read(2'd2, v1, t1);
    repeat (3) @(negedge clk);
    io_read(2'd2, v2, t2);
    chk("cycles_delta", v2 - v1, 32'(t2 - t1));
    chk("cycles_delta5", v2 - v1, 5);
    io_write(2'd0, 32'h0000_00A5);
    io_read(2'd0, v1, t1);
    chk("led_rb", v1, 32'h0000_00A5);
    // switch synchronizer: new value visible only after two edges
    @(negedge clk);
    sw = 8'h3C; MemRead = 1'b1; ALUResult = io_addr(2'd1);
    #1 chk("sw_lat0", ReadData, 32'h00);
    @(negedge clk); #1 chk("sw_lat1", ReadData, 32'h00);
    @(negedge clk); #1 chk("sw_lat2", ReadData, 32'h3C);
    MemRead = 1'b0;
    ram_access(1'b1, 32'h0000_0010, 32'h1234_5678, 2);
    mem[4] = 32'hCAFE_F00D;
    ram_access(1'b0, 32'h0000_0010, 32'h0, 0);
    ram_access(1'b0, 32'h0000_0010, 32'h0, TIMEOUT);
    io_write(2'd3, 32'h1);
    unmapped(32'h8000_0000, 1'b1);
    io_write(2'd3, 32'h1);
    unmapped(32'h0001_0010, 1'b0);
    io_write(2'd3, 32'h0);
    io_write(2'd3, 32'h1);
    unmapped(32'h0000_4000, 1'b1);
    ram_access(1'b1, 32'h0000_3FFC, 32'h0BAD_F00D, TIMEOUT - 1);
    ram_access(1'b0, 32'h0000_3FFF, 32'h0, 1);
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 5);
      waits = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
      a = {18'b0, 12'($urandom), 2'($urandom)};
      case (op)
        0: io_write(2'd0, $urandom);
        1: io_read(2'($urandom_range(0, 1)) | (($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0), v1, t1);
        2: ram_access(1'b1, a, $urandom, waits);
        3: ram_access(1'b0, a, 32'h0, waits);
        4: unmapped($urandom | 32'h0002_0000, 1'($urandom_range(0, 1)));
        default: io_write(2'd3, $urandom);
      endcase
    end
    @(negedge clk);
    MemRead = 1'b1; ALUResult = 32'h0000_0020;
    @(negedge clk);
    #1 chk("pend_req", 32'(ram_req), 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_req", 32'(ram_req), 0);
    chk("rst_mid_we", 32'(ram_we), 0);
    MemRead = 1'b0;
    #1;
    chk("rst_mid_idle", 32'(Stall), 0);
    m_led = '0; m_berr = 1'b0; m_rq = '0;
    chk("rst_mid_led", 32'(led), 0);
    chk("rst_mid_berr", 32'(bus_error), 0);
    @(negedge clk);
    rst = 1'b1;
    ram_access(1'b1, 32'h0000_0020, 32'h5555_AAAA, 1);
    ram_access(1'b0, 32'h0000_0020, 32'h0, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
